// File: rtl/reg_file_mp_if.sv
// Bus bundle for reg_file_mp: packed read ports, two write ports and ready.
// The datapath side drives master; the register file is the slave.
interface reg_file_mp_if #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int NRD   = 2
);
    localparam int AW = $clog2(NREGS);

    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*XLEN-1:0] rd_data;
    logic                we0;
    logic [AW-1:0]       waddr0;
    logic [XLEN-1:0]     wdata0;
    logic                we1;
    logic [AW-1:0]       waddr1;
    logic [XLEN-1:0]     wdata1;
    logic                ready;

    modport master (
        output rd_addr, we0, waddr0, wdata0, we1, waddr1, wdata1,
        input  rd_data, ready
    );

    modport slave (
        input  rd_addr, we0, waddr0, wdata0, we1, waddr1, wdata1,
        output rd_data, ready
    );
endinterface

// File: rtl/reg_file_mp.sv
// Multi-port integer register file: NRD combinational reads, two writes (port 1 wins),
// post-reset init sequencer. Define REG_FILE_BYPASS_EN for write-first read forwarding.
module reg_file_mp #(
    parameter int XLEN      = 32,
    parameter int NREGS     = 32,
    parameter int NRD       = 2,
    parameter int ZERO_REG  = 1,
    parameter int INIT_MODE = 0
) (
    input  logic          clock,
    input  logic          reset,
    reg_file_mp_if.slave  rf
);
    localparam int AW = $clog2(NREGS);

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t              state_q;
    logic [AW-1:0]       idx_q;
    logic                ready_q;
    logic [XLEN-1:0]     mem_q [NREGS];
    logic [XLEN-1:0]     mem_d [NREGS];
    logic                wr0_en;
    logic                wr1_en;
    logic [NRD*XLEN-1:0] rd_bus;

    function automatic logic [XLEN-1:0] init_value(input logic [AW-1:0] i);
        return (INIT_MODE != 0) ? XLEN'(i) : '0;
    endfunction

    function automatic logic is_zero_reg(input logic [AW-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    assign wr0_en = rf.we0 && !is_zero_reg(rf.waddr0);
    assign wr1_en = rf.we1 && !is_zero_reg(rf.waddr1);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_INIT;
            idx_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            case (state_q)
                ST_INIT: begin
                    idx_q <= idx_q + 1'b1;
                    if (idx_q == AW'(NREGS - 1)) begin
                        state_q <= ST_RUN;
                        ready_q <= 1'b1;
                    end
                end
                ST_RUN:  state_q <= ST_RUN;
                default: state_q <= ST_INIT;
            endcase
        end
    end

    // Port 1 is applied after port 0 so it overrides a same-address write.
    always_comb begin
        for (int i = 0; i < NREGS; i++) mem_d[i] = mem_q[i];
        if (state_q == ST_INIT) begin
            mem_d[idx_q] = init_value(idx_q);
        end else begin
            if (wr0_en) mem_d[rf.waddr0] = rf.wdata0;
            if (wr1_en) mem_d[rf.waddr1] = rf.wdata1;
        end
    end

    always_ff @(posedge clock) begin
        for (int i = 0; i < NREGS; i++) mem_q[i] <= mem_d[i];
    end

    always_comb begin
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] val;
        rd_bus = '0;
        addr   = '0;
        val    = '0;
        for (int k = 0; k < NRD; k++) begin
            addr = rf.rd_addr[k*AW +: AW];
            val  = mem_q[addr];
`ifdef REG_FILE_BYPASS_EN
            if (wr1_en && (rf.waddr1 == addr)) begin
                val = rf.wdata1;
            end else if (wr0_en && (rf.waddr0 == addr)) begin
                val = rf.wdata0;
            end
`endif
            if ((state_q != ST_RUN) || is_zero_reg(addr)) val = '0;
            rd_bus[k*XLEN +: XLEN] = val;
        end
    end

    assign rf.rd_data = rd_bus;
    assign rf.ready   = ready_q;
endmodule

// File: tb/tb_reg_file_mp.sv
// Randomized scoreboard bench for reg_file_mp against an array-based reference model.
module tb_reg_file_mp;
    localparam int XLEN      = 32;
    localparam int NREGS     = 32;
    localparam int NRD       = 2;
    localparam int ZERO_REG  = 1;
    localparam int INIT_MODE = 1;
    localparam int AW        = $clog2(NREGS);

    logic clock = 1'b0;
    logic reset;

    always #5 clock = ~clock;

    reg_file_mp_if #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) rf_if ();

    reg_file_mp #(
        .XLEN(XLEN), .NREGS(NREGS), .NRD(NRD),
        .ZERO_REG(ZERO_REG), .INIT_MODE(INIT_MODE)
    ) dut (
        .clock (clock),
        .reset (reset),
        .rf    (rf_if)
    );

    typedef struct {
        string           name;
        int              port;
        logic [XLEN-1:0] exp;
    } exp_t;

    exp_t            sb_q[$];
    int              checks = 0;
    int              errors = 0;
    logic [XLEN-1:0] model [NREGS];
    int              edges = 0;

    function automatic bit model_ready();
        return !reset && (edges >= NREGS);
    endfunction

    function automatic logic [XLEN-1:0] model_read(input int a);
        if (!model_ready()) return '0;
        if ((ZERO_REG != 0) && (a == 0)) return '0;
`ifdef REG_FILE_BYPASS_EN
        if (rf_if.we1 && (int'(rf_if.waddr1) == a)) return rf_if.wdata1;
        if (rf_if.we0 && (int'(rf_if.waddr0) == a)) return rf_if.wdata0;
`endif
        return model[a];
    endfunction

    // Queue expectations for the current inputs, then advance the model one edge.
    task automatic step(input string name);
        int a;
        sb_q.push_back('{{name, ".ready"}, -1, XLEN'(model_ready())});
        for (int k = 0; k < NRD; k++) begin
            a = int'(rf_if.rd_addr[k*AW +: AW]);
            sb_q.push_back('{$sformatf("%s.rd%0d[%0d]", name, k, a), k, model_read(a)});
        end
        @(posedge clock);
        if (reset) begin
            edges = 0;
        end else if (edges < NREGS) begin
            edges++;
            if (edges == NREGS)
                for (int i = 0; i < NREGS; i++) model[i] = (INIT_MODE != 0) ? XLEN'(i) : '0;
        end else begin
            if (rf_if.we0 && !((ZERO_REG != 0) && (rf_if.waddr0 == '0)))
                model[rf_if.waddr0] = rf_if.wdata0;
            if (rf_if.we1 && !((ZERO_REG != 0) && (rf_if.waddr1 == '0)))
                model[rf_if.waddr1] = rf_if.wdata1;
        end
        #1;
    endtask

    task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        rf_if.rd_addr = {a1, a0};
    endtask

    task automatic set_wr(input logic e0, input logic [AW-1:0] a0, input logic [XLEN-1:0] d0,
                          input logic e1, input logic [AW-1:0] a1, input logic [XLEN-1:0] d1);
        rf_if.we0 = e0; rf_if.waddr0 = a0; rf_if.wdata0 = d0;
        rf_if.we1 = e1; rf_if.waddr1 = a1; rf_if.wdata1 = d1;
    endtask

    function automatic logic [AW-1:0] rnd_addr();
        if ($urandom_range(0, 3) == 0) return AW'($urandom_range(0, NREGS - 1));
        return AW'($urandom_range(0, 7));
    endfunction

    task automatic rnd_inputs();
        set_wr(1'($urandom_range(0, 1)), rnd_addr(), XLEN'($urandom),
               1'($urandom_range(0, 1)), rnd_addr(), XLEN'($urandom));
        set_rd(rnd_addr(), rnd_addr());
    endtask

    always @(negedge clock) begin : monitor
        exp_t            e;
        logic [XLEN-1:0] act;
        while (sb_q.size() > 0) begin
            e   = sb_q.pop_front();
            act = (e.port < 0) ? XLEN'(rf_if.ready) : rf_if.rd_data[e.port*XLEN +: XLEN];
            checks++;
            if (act !== e.exp) begin
                errors++;
                $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
            end
        end
    end

    initial begin
        reset = 1'b1;
        set_wr(1'b0, '0, '0, 1'b0, '0, '0);
        set_rd('0, '0);
        for (int i = 0; i < NREGS; i++) model[i] = '0;
        @(posedge clock);
        #1;

        set_wr(1'b1, AW'(9), 32'hAAAA_5555, 1'b0, '0, '0);
        set_rd(AW'(5), AW'(9));
        repeat (2) step("rst_hold");
        reset = 1'b0;
        repeat (NREGS) step("init");
        rf_if.we0 = 1'b0;
        step("post_init");

        set_wr(1'b1, AW'(3), 32'hDEAD_BEEF, 1'b0, '0, '0);
        set_rd(AW'(5), AW'(3));
        step("wb_same");
        rf_if.we0 = 1'b0;
        step("wb_next");

        set_wr(1'b1, AW'(7), 32'h1111_1111, 1'b1, AW'(7), 32'h2222_2222);
        set_rd(AW'(7), AW'(3));
        step("coll_same");
        set_wr(1'b0, '0, '0, 1'b0, '0, '0);
        step("coll_next");

        set_wr(1'b0, '0, '0, 1'b1, AW'(0), 32'hFFFF_FFFF);
        set_rd(AW'(0), AW'(0));
        step("zero_same");
        rf_if.we1 = 1'b0;
        step("zero_next");

        repeat (400) begin
            rnd_inputs();
            step("rand");
        end

        reset = 1'b1;
        repeat (2) step("rst_run");
        reset = 1'b0;
        repeat (10) begin
            rnd_inputs();
            step("reinit");
        end
        reset = 1'b1;
        repeat (2) step("rst_mid_init");
        reset = 1'b0;
        repeat (NREGS) begin
            rnd_inputs();
            step("reinit2");
        end

        set_wr(1'b0, '0, '0, 1'b0, '0, '0);
        for (int i = 0; i < NREGS; i += 2) begin
            set_rd(AW'(i), AW'(i + 1));
            step("sweep");
        end

        @(negedge clock);
        #1;
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
